fetch_stage: RTL
================

# fetch_stage

Instruction-fetch (F) stage of the five-stage MIPS pipeline. It owns the program counter, selects the next PC from sequential, branch, jump and jump-register sources, drives the instruction-memory address, and presents `PC_F`/`Instr_F` to the F/D pipeline register directly downstream. Control-transfer decisions arrive from the D stage; branches use one delay slot, so the instruction fetched after a branch always enters the pipeline.

## Interface
- `PC_RESET`, default `32'h0000_3000`: PC value loaded on reset.
- `clk`  input  1: sole clock; all state updates on its rising edge.
- `reset`  input  1: synchronous, active-high; overrides every other input.
- `enable_F`  input  1: PC update enable; 0 = stall, PC holds.
- `NPC_sel`  input  3: next-PC source from D: 0 = PC_F+4, 1 = conditional branch, 2 = j/jal, 3 = jr/jalr, 4–7 reserved.
- `cmp_D`  input  1: branch condition result from the D-stage comparator; 1 = taken.
- `PC_D`  input  32: PC of the instruction currently in D.
- `Imm16_D`  input  16: branch offset field of the D instruction.
- `Index26_D`  input  26: jump index field of the D instruction.
- `RS_D`  input  32: forwarded rs value in D, used as the jr target.
- `i_inst_rdata`  input  32: instruction word read from instruction memory at `i_inst_addr`.
- `i_inst_addr`  output  32: instruction-memory address; equals `PC_F`.
- `PC_F`  output  32: current fetch PC, to the F/D register.
- `Instr_F`  output  32: fetched instruction, to the F/D register; combinational copy of `i_inst_rdata`.

## Operation
- State: one 32-bit PC register; `PC_F` = `i_inst_addr` = PC register output.
- Next-PC computation (combinational, all modulo 2^32):
  - seq = PC_F + 4.
  - branch = PC_D + 4 + (sign_extend(Imm16_D) << 2).
  - jump = {PC_D[31:28], Index26_D, 2'b00}; the upper nibble comes from PC_D, not PC_F.
  - jr = RS_D, used unmodified; low two bits not masked.
- Selection:
  - NPC_sel=0 → seq.
  - NPC_sel=1 and cmp_D=1 → branch.
  - NPC_sel=1 and cmp_D=0 → seq.
  - NPC_sel=2 → jump.
  - NPC_sel=3 → jr.
  - NPC_sel 4–7 → seq.
- Delay slot: while a control instruction is in D, F holds its delay slot at PC_D+4; the selected target becomes `PC_F` on the following edge.
- No alignment, range or exception checking in this block.

## Timing
- Reset: on a rising edge with `reset`=1, PC ← `PC_RESET` regardless of `enable_F`/`NPC_sel`. `PC_F`/`i_inst_addr` = 0x0000_3000 from the cycle after that edge. `Instr_F` follows memory.
- Normal edge (`reset`=0, `enable_F`=1): PC ← selected next PC; one-cycle latency from D-stage decision to new `PC_F`.
- Stall edge (`reset`=0, `enable_F`=0): PC unchanged. Any concurrent `NPC_sel`/`cmp_D` is ignored. D is stalled in the same cycle, so the decision is re-presented and taken on the first enabled edge.
- Reset asserted during a stall: reset wins; PC ← `PC_RESET`.
- Wrap-around: seq from 0xFFFF_FFFC gives 0x0000_0000; branch arithmetic wraps identically.
- Outputs are stable between edges except `Instr_F`, which tracks `i_inst_rdata` combinationally.
- No X propagation from reserved `NPC_sel` codes; they behave exactly as 0.

## Test plan
- Reset then sequential run: hold `reset` one edge, then `NPC_sel`=0, `enable_F`=1 for 3 edges → `PC_F` = 0x3000, 0x3004, 0x3008, 0x300C.
- Stall: at `PC_F`=0x3008, `enable_F`=0 for 2 edges → `PC_F` stays 0x3008; re-enable → 0x300C.
- Branch taken and not taken: `PC_D`=0x3010, `Imm16_D`=0xFFFC, `NPC_sel`=1, `cmp_D`=1 → next `PC_F`=0x3004. Same inputs with `cmp_D`=0 → next `PC_F` = PC_F+4.
- Jump and jr:
  - `PC_D`=0x3020, `Index26_D`=0x0000C10, `NPC_sel`=2 → `PC_F`=0x0000_3040.
  - `NPC_sel`=3, `RS_D`=0x0000_3100 → `PC_F`=0x3100.
  - Reserved `NPC_sel`=5 → `PC_F`+4.
- Stall concurrent with branch: `NPC_sel`=1, `cmp_D`=1, `enable_F`=0 → PC holds. Next edge with `enable_F`=1 and the same inputs → branch target loaded.
- Reset mid-stall and wrap:
  - `enable_F`=0, `reset`=1 at `PC_F`=0x3050 → `PC_F`=0x3000.
  - `jr` to 0xFFFF_FFFC then `NPC_sel`=0 → `PC_F`=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC from sequential,
// branch, jump and jump-register sources, and presents PC/instruction to F/D.
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable_F,
   input  logic [2:0]  NPC_sel,
   input  logic        cmp_D,
   input  logic [31:0] PC_D,
   input  logic [15:0] Imm16_D,
   input  logic [25:0] Index26_D,
   input  logic [31:0] RS_D,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] i_inst_addr,
   output logic [31:0] PC_F,
   output logic [31:0] Instr_F
);

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] NPC_SEQ    = 3'd0;
   localparam logic [2:0] NPC_BRANCH = 3'd1;
   localparam logic [2:0] NPC_JUMP   = 3'd2;
   localparam logic [2:0] NPC_JR     = 3'd3;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] branch_pc;
   logic [XLEN-1:0] jump_pc;
   logic [XLEN-1:0] branch_off;
   logic [XLEN-1:0] next_pc;

   // Branch and jump targets are relative to the instruction in D, not F.
   assign seq_pc     = pc + XLEN'(4);
   assign branch_off = {{14{Imm16_D[15]}}, Imm16_D, 2'b00};
   assign branch_pc  = PC_D + XLEN'(4) + branch_off;
   assign jump_pc    = {PC_D[31:28], Index26_D, 2'b00};

   // Reserved selector codes fall through to sequential fetch.
   always_comb begin
      next_pc = seq_pc;
      case (NPC_sel)
         NPC_SEQ:    next_pc = seq_pc;
         NPC_BRANCH: next_pc = cmp_D ? branch_pc : seq_pc;
         NPC_JUMP:   next_pc = jump_pc;
         NPC_JR:     next_pc = RS_D;
         default:    next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= PC_RESET;
      end else if (enable_F) begin
         pc <= next_pc;
      end
   end

   assign PC_F        = pc;
   assign i_inst_addr = pc;
   assign Instr_F     = i_inst_rdata;

endmodule
